// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and memory requester identifiers.
package core_pkg;

  // Datapath width and the matching byte-lane write-mask width.
  localparam int Xlen     = 32;
  localparam int MaskBits = Xlen / 8;

  // Identifies which requester issued a memory transaction.
  typedef enum logic {
    ReqFetch,
    ReqLsu
  } mem_req_id_e;

  // Returns the requester that is not the given one; used to hand priority over.
  function automatic mem_req_id_e other_req(input mem_req_id_e id);
    return (id == ReqFetch) ? ReqLsu : ReqFetch;
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered memory requests.
// Circular buffer with wrap-around pointers and an explicit occupancy count.
module mem_id_fifo
  import core_pkg::*;
#(
  parameter int  Depth  = 2,
  parameter type elem_t = mem_req_id_e
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  elem_t push_id,
  input  logic  pop,
  output elem_t head,
  output logic  full,
  output logic  empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  elem_t            slots [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  // Advances a pointer by one slot, wrapping at the last entry.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Status flags and guarded push/pop so an overflow or underflow cannot corrupt state.
  always_comb begin
    full    = (count == CntW'(Depth));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = slots[rd_ptr];
  end

  // Storage write: the new ID lands in the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        slots[i] <= elem_t'(0);
      end
    end else if (do_push) begin
      slots[wr_ptr] <= push_id;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and
// the LSU. Requests pass through combinationally; an ID FIFO remembers who
// issued each accepted request so in-order responses are routed back.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [Xlen-1:0]     if_addr_i,
  input  logic [Xlen-1:0]     if_wdata_i,
  input  logic [MaskBits-1:0] if_wmask_i,
  output logic [Xlen-1:0]     if_rdata_o,
  output logic                if_rvalid_o,

  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic [Xlen-1:0]     lsu_addr_i,
  input  logic [Xlen-1:0]     lsu_wdata_i,
  input  logic [MaskBits-1:0] lsu_wmask_i,
  output logic [Xlen-1:0]     lsu_rdata_o,
  output logic                lsu_rvalid_o,

  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i,

  output logic                spurious_rvalid_o
);

  mem_req_id_e grant;
  mem_req_id_e rr_q;
  mem_req_id_e lock_id_q;
  logic        lock_q;
  logic        granted_valid;
  logic        accept;
  logic        stall;
  logic        rsp_hit;
  logic        rsp_spurious;
  logic        spurious_q;

  mem_req_id_e head;
  logic        full;
  logic        empty;

  // Outstanding-request tracker: one entry per accepted request, popped per response.
  mem_id_fifo #(
    .Depth  (MaxOutstanding),
    .elem_t (mem_req_id_e)
  ) u_id_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (accept),
    .push_id (grant),
    .pop     (rsp_hit),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Grant selection: a held lock wins, then a lone requester, then round-robin on contention.
  always_comb begin
    grant = rr_q;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (if_valid_i && !lsu_valid_i) begin
      grant = ReqFetch;
    end else if (lsu_valid_i && !if_valid_i) begin
      grant = ReqLsu;
    end
  end

  // Downstream request and requester readys; everything is held low while full or in reset.
  always_comb begin
    granted_valid = (grant == ReqFetch) ? if_valid_i : lsu_valid_i;
    mem_valid_o   = granted_valid && !full && !rst_i;
    accept        = mem_valid_o && mem_ready_i;
    stall         = mem_valid_o && !mem_ready_i;
    if_ready_o    = (grant == ReqFetch) && mem_ready_i && !full && !rst_i;
    lsu_ready_o   = (grant == ReqLsu) && mem_ready_i && !full && !rst_i;
  end

  // Payload mux follows the grant even when no request is presented.
  always_comb begin
    mem_addr_o  = if_addr_i;
    mem_wdata_o = if_wdata_i;
    mem_wmask_o = if_wmask_i;
    if (grant == ReqLsu) begin
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
      mem_wmask_o = lsu_wmask_i;
    end
  end

  // Response routing: the FIFO head names the owner; an empty FIFO means the response is bogus.
  always_comb begin
    rsp_hit      = mem_rvalid_i && !empty && !rst_i;
    rsp_spurious = mem_rvalid_i && empty && !rst_i;
    if_rvalid_o  = rsp_hit && (head == ReqFetch);
    lsu_rvalid_o = rsp_hit && (head == ReqLsu);
    if_rdata_o   = mem_rdata_i;
    lsu_rdata_o  = mem_rdata_i;
  end

  // Round-robin pointer: after an accept the other requester gets priority; LSU first out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= ReqLsu;
    end else if (accept) begin
      rr_q <= other_req(grant);
    end
  end

  // Grant lock keeps the downstream payload stable while memory applies backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= ReqFetch;
    end else if (accept) begin
      lock_q    <= 1'b0;
    end else if (stall) begin
      lock_q    <= 1'b1;
      lock_id_q <= grant;
    end
  end

  // Sticky record of any response that arrived with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spurious_q <= 1'b0;
    end else if (rsp_spurious) begin
      spurious_q <= 1'b1;
    end
  end

  assign spurious_rvalid_o = spurious_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected accepts
// and responses into queues, a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import core_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                if_valid_i;
  logic                if_ready_o;
  logic [Xlen-1:0]     if_addr_i;
  logic [Xlen-1:0]     if_wdata_i;
  logic [MaskBits-1:0] if_wmask_i;
  logic [Xlen-1:0]     if_rdata_o;
  logic                if_rvalid_o;
  logic                lsu_valid_i;
  logic                lsu_ready_o;
  logic [Xlen-1:0]     lsu_addr_i;
  logic [Xlen-1:0]     lsu_wdata_i;
  logic [MaskBits-1:0] lsu_wmask_i;
  logic [Xlen-1:0]     lsu_rdata_o;
  logic                lsu_rvalid_o;
  logic                mem_valid_o;
  logic                mem_ready_i;
  logic [Xlen-1:0]     mem_addr_o;
  logic [Xlen-1:0]     mem_wdata_o;
  logic [MaskBits-1:0] mem_wmask_o;
  logic [Xlen-1:0]     mem_rdata_i;
  logic                mem_rvalid_i;
  logic                spurious_rvalid_o;

  localparam logic [Xlen-1:0] WdataSalt = 32'h5A5A_0000;

  int check_count = 0;
  int error_count = 0;

  logic [Xlen-1:0]     exp_acc_addr [$];
  logic [MaskBits-1:0] exp_acc_mask [$];
  logic                exp_rsp_lsu  [$];
  logic [Xlen-1:0]     exp_rsp_data [$];

  logic [Xlen-1:0]     mon_addr;
  logic [MaskBits-1:0] mon_mask;
  logic                mon_lsu;
  logic [Xlen-1:0]     mon_data;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .MaxOutstanding (2)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .if_valid_i        (if_valid_i),
    .if_ready_o        (if_ready_o),
    .if_addr_i         (if_addr_i),
    .if_wdata_i        (if_wdata_i),
    .if_wmask_i        (if_wmask_i),
    .if_rdata_o        (if_rdata_o),
    .if_rvalid_o       (if_rvalid_o),
    .lsu_valid_i       (lsu_valid_i),
    .lsu_ready_o       (lsu_ready_o),
    .lsu_addr_i        (lsu_addr_i),
    .lsu_wdata_i       (lsu_wdata_i),
    .lsu_wmask_i       (lsu_wmask_i),
    .lsu_rdata_o       (lsu_rdata_o),
    .lsu_rvalid_o      (lsu_rvalid_o),
    .mem_valid_o       (mem_valid_o),
    .mem_ready_i       (mem_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_wmask_o       (mem_wmask_o),
    .mem_rdata_i       (mem_rdata_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .spurious_rvalid_o (spurious_rvalid_o)
  );

  // Compares one observed value against the bench's expectation and tallies the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drives every requester and memory-side input for the coming cycle.
  task automatic applyStimulus(input logic ifv, input logic [31:0] ifa, input logic [3:0] ifm,
                               input logic lv, input logic [31:0] la, input logic [3:0] lm,
                               input logic rdy, input logic rv, input logic [31:0] rd);
    if_valid_i   = ifv;
    if_addr_i    = ifa;
    if_wdata_i   = ifa ^ WdataSalt;
    if_wmask_i   = ifm;
    lsu_valid_i  = lv;
    lsu_addr_i   = la;
    lsu_wdata_i  = la ^ WdataSalt;
    lsu_wmask_i  = lm;
    mem_ready_i  = rdy;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
  endtask

  task automatic expectAccept(input logic [31:0] addr, input logic [3:0] mask);
    exp_acc_addr.push_back(addr);
    exp_acc_mask.push_back(mask);
  endtask

  task automatic expectResponse(input logic to_lsu, input logic [31:0] data);
    exp_rsp_lsu.push_back(to_lsu);
    exp_rsp_data.push_back(data);
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every downstream accept and every routed response is matched against the queues.
  always @(negedge clk_i) begin
    if (mem_valid_o && mem_ready_i) begin
      if (exp_acc_addr.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL accept_unexpected actual addr=0x%0h expected none", mem_addr_o);
      end else begin
        mon_addr = exp_acc_addr.pop_front();
        mon_mask = exp_acc_mask.pop_front();
        checkOutput("accept_addr", mem_addr_o, mon_addr);
        checkOutput("accept_wdata", mem_wdata_o, mon_addr ^ WdataSalt);
        checkOutput("accept_wmask", 32'(mem_wmask_o), 32'(mon_mask));
      end
    end
    if (if_rvalid_o || lsu_rvalid_o) begin
      if (exp_rsp_lsu.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL response_unexpected actual if=%0b lsu=%0b expected none", if_rvalid_o, lsu_rvalid_o);
      end else begin
        mon_lsu  = exp_rsp_lsu.pop_front();
        mon_data = exp_rsp_data.pop_front();
        checkOutput("rsp_port_if", 32'(if_rvalid_o), 32'(!mon_lsu));
        checkOutput("rsp_port_lsu", 32'(lsu_rvalid_o), 32'(mon_lsu));
        checkOutput("rsp_data", mon_lsu ? lsu_rdata_o : if_rdata_o, mon_data);
      end
    end
  end

  initial begin
    // Reset: outputs must be quiet even with requests and a response present.
    rst_i = 1'b1;
    applyStimulus(1, 32'h10, 4'h0, 1, 32'h20, 4'hF, 1, 1, 32'h99);
    nextCycle();
    @(negedge clk_i);
    checkOutput("rst_mem_valid", 32'(mem_valid_o), 0);
    checkOutput("rst_if_ready", 32'(if_ready_o), 0);
    checkOutput("rst_lsu_ready", 32'(lsu_ready_o), 0);
    checkOutput("rst_if_rvalid", 32'(if_rvalid_o), 0);
    checkOutput("rst_lsu_rvalid", 32'(lsu_rvalid_o), 0);
    checkOutput("rst_spurious", 32'(spurious_rvalid_o), 0);
    nextCycle();
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("idle_spurious", 32'(spurious_rvalid_o), 0);
    checkOutput("idle_mem_valid", 32'(mem_valid_o), 0);

    // Contention: LSU wins first after reset, then fetch; responses route in order.
    nextCycle();
    applyStimulus(1, 32'h200, 4'h0, 1, 32'h100, 4'hF, 1, 0, 0);
    expectAccept(32'h100, 4'hF);
    @(negedge clk_i);
    checkOutput("contend_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("contend_if_ready0", 32'(if_ready_o), 0);
    nextCycle();
    applyStimulus(1, 32'h200, 4'h0, 0, 0, 0, 1, 0, 0);
    expectAccept(32'h200, 4'h0);
    @(negedge clk_i);
    checkOutput("contend_if_ready", 32'(if_ready_o), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hAA);
    expectResponse(1, 32'hAA);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hBB);
    expectResponse(0, 32'hBB);

    // Lock: stalled fetch keeps the grant although LSU (which has priority) shows up.
    nextCycle();
    applyStimulus(1, 32'h40, 4'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("lock_mem_valid", 32'(mem_valid_o), 1);
    checkOutput("lock_addr_c0", mem_addr_o, 32'h40);
    checkOutput("lock_if_ready0", 32'(if_ready_o), 0);
    nextCycle();
    applyStimulus(1, 32'h40, 4'h0, 1, 32'h300, 4'h3, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("lock_addr_c1", mem_addr_o, 32'h40);
    checkOutput("lock_lsu_ready0", 32'(lsu_ready_o), 0);
    nextCycle();
    @(negedge clk_i);
    checkOutput("lock_addr_c2", mem_addr_o, 32'h40);
    nextCycle();
    applyStimulus(1, 32'h40, 4'h0, 1, 32'h300, 4'h3, 1, 0, 0);
    expectAccept(32'h40, 4'h0);
    @(negedge clk_i);
    checkOutput("lock_if_ready", 32'(if_ready_o), 1);
    checkOutput("lock_lsu_wait", 32'(lsu_ready_o), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h300, 4'h3, 1, 0, 0);
    expectAccept(32'h300, 4'h3);
    @(negedge clk_i);
    checkOutput("lock_lsu_next", 32'(lsu_ready_o), 1);

    // Full: two outstanding blocks everything; a pop frees the slot only next cycle.
    nextCycle();
    applyStimulus(1, 32'h500, 4'h0, 1, 32'h600, 4'hC, 1, 0, 0);
    @(negedge clk_i);
    checkOutput("full_if_ready", 32'(if_ready_o), 0);
    checkOutput("full_lsu_ready", 32'(lsu_ready_o), 0);
    checkOutput("full_mem_valid", 32'(mem_valid_o), 0);
    nextCycle();
    applyStimulus(1, 32'h500, 4'h0, 1, 32'h600, 4'hC, 1, 1, 32'h11);
    expectResponse(0, 32'h11);
    @(negedge clk_i);
    checkOutput("full_no_bypass_valid", 32'(mem_valid_o), 0);
    checkOutput("full_no_bypass_ready", 32'(if_ready_o), 0);
    nextCycle();
    applyStimulus(1, 32'h500, 4'h0, 1, 32'h600, 4'hC, 1, 0, 0);
    expectAccept(32'h500, 4'h0);
    @(negedge clk_i);
    checkOutput("full_freed_if_ready", 32'(if_ready_o), 1);
    checkOutput("full_freed_lsu_ready", 32'(lsu_ready_o), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h600, 4'hC, 1, 1, 32'h22);
    expectResponse(1, 32'h22);
    @(negedge clk_i);
    checkOutput("full_again_lsu_ready", 32'(lsu_ready_o), 0);

    // Simultaneous push and pop: old fetch head answered while LSU is accepted.
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h600, 4'hC, 1, 1, 32'h33);
    expectAccept(32'h600, 4'hC);
    expectResponse(0, 32'h33);
    @(negedge clk_i);
    checkOutput("pushpop_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("pushpop_if_rvalid", 32'(if_rvalid_o), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h44);
    expectResponse(1, 32'h44);
    @(negedge clk_i);
    checkOutput("pushpop_lsu_rvalid", 32'(lsu_rvalid_o), 1);

    // Spurious: response with nothing outstanding, even alongside a new accept.
    nextCycle();
    applyStimulus(1, 32'h700, 4'h0, 0, 0, 0, 1, 1, 32'h55);
    expectAccept(32'h700, 4'h0);
    @(negedge clk_i);
    checkOutput("spur_if_rvalid", 32'(if_rvalid_o), 0);
    checkOutput("spur_lsu_rvalid", 32'(lsu_rvalid_o), 0);
    checkOutput("spur_flag_pre", 32'(spurious_rvalid_o), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    checkOutput("spur_flag_set", 32'(spurious_rvalid_o), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h66);
    expectResponse(0, 32'h66);
    @(negedge clk_i);
    checkOutput("spur_flag_held", 32'(spurious_rvalid_o), 1);

    // Reset mid-operation: leave fetch priority pending, then reset with two outstanding.
    nextCycle();
    applyStimulus(1, 32'h900, 4'h0, 0, 0, 0, 1, 0, 0);
    expectAccept(32'h900, 4'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h800, 4'hF, 1, 0, 0);
    expectAccept(32'h800, 4'hF);
    nextCycle();
    rst_i = 1'b1;
    applyStimulus(1, 32'hB00, 4'h0, 1, 32'hA00, 4'h1, 1, 0, 0);
    @(negedge clk_i);
    checkOutput("midrst_mem_valid", 32'(mem_valid_o), 0);
    checkOutput("midrst_if_ready", 32'(if_ready_o), 0);
    checkOutput("midrst_lsu_ready", 32'(lsu_ready_o), 0);
    nextCycle();
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h77);
    @(negedge clk_i);
    checkOutput("stale_if_rvalid", 32'(if_rvalid_o), 0);
    checkOutput("stale_lsu_rvalid", 32'(lsu_rvalid_o), 0);
    checkOutput("midrst_spur_cleared", 32'(spurious_rvalid_o), 0);
    nextCycle();
    applyStimulus(1, 32'hB00, 4'h0, 1, 32'hA00, 4'h1, 1, 0, 0);
    expectAccept(32'hA00, 4'h1);
    @(negedge clk_i);
    checkOutput("stale_spur_set", 32'(spurious_rvalid_o), 1);
    checkOutput("midrst_lsu_prio", 32'(lsu_ready_o), 1);
    checkOutput("midrst_if_wait", 32'(if_ready_o), 0);
    nextCycle();
    applyStimulus(1, 32'hB00, 4'h0, 0, 0, 0, 1, 0, 0);
    expectAccept(32'hB00, 4'h0);
    @(negedge clk_i);
    checkOutput("midrst_if_next", 32'(if_ready_o), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("accepts_drained", 32'(exp_acc_addr.size()), 0);
    checkOutput("responses_drained", 32'(exp_rsp_lsu.size()), 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
